// File: rtl/cpu_player.sv
// Computer opponent: waits TICK_DIV cycles, samples rnd against difficulty and
// issues a single-cycle press followed by a cooldown; halts for good on game_over.
module cpu_player #(
   parameter int TICK_DIV    = 1024,
   parameter int COOL_CYCLES = 4
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       enable,
   input  logic [9:0] rnd,
   input  logic [8:0] difficulty,
   input  logic       game_over,
   output logic       press,
   output logic [7:0] press_cnt
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT     = 3'd1,
      SAMPLE   = 3'd2,
      PRESS    = 3'd3,
      COOLDOWN = 3'd4,
      HALT     = 3'd5
   } state_t;

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [7:0]  COOL_LAST = 8'(COOL_CYCLES - 1);

   state_t      state_r;
   state_t      next_state_s;
   logic [15:0] tick_r;
   logic [15:0] tick_nxt_s;
   logic [7:0]  cool_r;
   logic [7:0]  cool_nxt_s;
   logic        press_r;
   logic [7:0]  press_cnt_r;
   logic        hit_s;

   assign hit_s     = (rnd < {1'b0, difficulty});
   assign press     = press_r;
   assign press_cnt = press_cnt_r;

   // Next-state and counter update; game_over outranks enable, HALT is sticky.
   always_comb begin
      next_state_s = state_r;
      tick_nxt_s   = tick_r;
      cool_nxt_s   = cool_r;
      if (game_over) begin
         next_state_s = HALT;
         tick_nxt_s   = 16'd0;
         cool_nxt_s   = 8'd0;
      end else if (!enable && (state_r != HALT)) begin
         next_state_s = IDLE;
         tick_nxt_s   = 16'd0;
         cool_nxt_s   = 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               tick_nxt_s   = 16'd0;
               cool_nxt_s   = 8'd0;
               next_state_s = WAIT;
            end
            WAIT: begin
               if (tick_r == TICK_LAST) begin
                  next_state_s = SAMPLE;
                  tick_nxt_s   = 16'd0;
               end else begin
                  tick_nxt_s   = tick_r + 16'd1;
               end
            end
            SAMPLE: begin
               tick_nxt_s = 16'd0;
               if (hit_s) begin
                  next_state_s = PRESS;
               end else begin
                  next_state_s = WAIT;
               end
            end
            PRESS: begin
               cool_nxt_s   = 8'd0;
               next_state_s = COOLDOWN;
            end
            COOLDOWN: begin
               if (cool_r == COOL_LAST) begin
                  next_state_s = WAIT;
                  cool_nxt_s   = 8'd0;
                  tick_nxt_s   = 16'd0;
               end else begin
                  cool_nxt_s   = cool_r + 8'd1;
               end
            end
            HALT: begin
               next_state_s = HALT;
               tick_nxt_s   = 16'd0;
               cool_nxt_s   = 8'd0;
            end
            default: begin
               next_state_s = IDLE;
               tick_nxt_s   = 16'd0;
               cool_nxt_s   = 8'd0;
            end
         endcase
      end
   end

   // State, counters and registered outputs; press is decoded from the next state
   // so it lines up with the PRESS cycle itself.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r     <= IDLE;
         tick_r      <= 16'd0;
         cool_r      <= 8'd0;
         press_r     <= 1'b0;
         press_cnt_r <= 8'd0;
      end else begin
         state_r <= next_state_s;
         tick_r  <= tick_nxt_s;
         cool_r  <= cool_nxt_s;
         press_r <= (next_state_s == PRESS);
         if ((next_state_s == PRESS) && (press_cnt_r != 8'd255)) begin
            press_cnt_r <= press_cnt_r + 8'd1;
         end else begin
            press_cnt_r <= press_cnt_r;
         end
      end
   end

endmodule
